// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer: FSM state
// encodings, legal WIDTH range and a range-check helper.
package sipo_pkg;

  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 32;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  function automatic bit width_legal(input int unsigned w);
    return (w >= WidthMin) && (w <= WidthMax);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for sipo_deser. Flags the edge on which the
// last frame bit is sampled and presents the assembled data word alongside it.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned FRAME_LEN = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             in_valid,
  input  logic             frame_sync,
  output logic             word_done,
  output logic [WIDTH-1:0] word,
  output logic             parity_bad
);

  localparam int unsigned          CntW    = $clog2(FRAME_LEN + 1);
  localparam logic [CntW-1:0]      LastCnt = CntW'(FRAME_LEN - 1);
  localparam logic [CntW-1:0]      DataCnt = CntW'(WIDTH);
  localparam bit                   HasPar  = FRAME_LEN > WIDTH;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             is_data;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    word_done = 1'b0;
    // Bits past the data bits (the parity bit) are checked, not stored.
    is_data   = count_q < DataCnt;
    if (frame_sync) begin
      state_d = StIdle;
      count_d = '0;
      data_d  = '0;
    end else if (in_valid) begin
      if (is_data) begin
        if (MSB_FIRST != 0) begin
          data_d = {data_q[WIDTH-2:0], serial_in};
        end else begin
          data_d = {serial_in, data_q[WIDTH-1:1]};
        end
      end
      if (count_q == LastCnt) begin
        state_d   = StIdle;
        count_d   = '0;
        word_done = 1'b1;
      end else if (state_q == StIdle) begin
        state_d = StShift;
        count_d = CntW'(1);
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  assign word       = data_d;
  assign parity_bad = HasPar && ((^data_q) != serial_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with valid/ready output register and
// sticky overrun/parity flags. Define SIPO_DESER_PARITY_EN for a trailing
// even-parity bit per frame.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             in_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             parity_err
);

`ifdef SIPO_DESER_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("sipo_deser: WIDTH out of legal range");
  end

  logic             word_done;
  logic [WIDTH-1:0] word;
  logic             parity_bad;

  logic [WIDTH-1:0] parallel_q, parallel_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             parity_err_q, parity_err_d;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .FRAME_LEN (FrameLen)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .in_valid   (in_valid),
    .frame_sync (frame_sync),
    .word_done  (word_done),
    .word       (word),
    .parity_bad (parity_bad)
  );

  always_comb begin
    parallel_d   = parallel_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_clr ? 1'b0 : overrun_q;
    parity_err_d = overrun_clr ? 1'b0 : parity_err_q;
    if (word_done) begin
      // A pending word survives; a new one is only taken if the slot frees now.
      if (!out_valid_q || out_ready) begin
        parallel_d  = word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      if (parity_bad) begin
        parity_err_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parallel_q   <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parallel_q   <= parallel_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parallel_out = parallel_q;
  assign out_valid    = out_valid_q;
  assign overrun      = overrun_q;
  assign parity_err   = parity_err_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: an LSB-first and an MSB-first WIDTH=4
// instance share one stimulus stream.
module tb_sipo_deser;

`ifdef SIPO_DESER_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk = 1'b0;
  logic       rst, serial_in, in_valid, frame_sync, out_ready, overrun_clr;
  logic [3:0] po_l, po_m;
  logic       ov_l, ov_m, ovr_l, ovr_m, pe_l, pe_m;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk (clk), .rst (rst), .serial_in (serial_in), .in_valid (in_valid),
    .frame_sync (frame_sync), .parallel_out (po_l), .out_valid (ov_l),
    .out_ready (out_ready), .overrun (ovr_l), .overrun_clr (overrun_clr),
    .parity_err (pe_l)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
    .clk (clk), .rst (rst), .serial_in (serial_in), .in_valid (in_valid),
    .frame_sync (frame_sync), .parallel_out (po_m), .out_valid (ov_m),
    .out_ready (out_ready), .overrun (ovr_m), .overrun_clr (overrun_clr),
    .parity_err (pe_m)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // s[0] is sent first; in parity builds an even-parity bit follows (inverted if par_bad).
  task automatic send_seq(input logic [3:0] s, input int gap, input logic par_bad);
    logic [4:0] bits;
    bits = {(^s) ^ par_bad, s};
    for (int i = 0; i < FL; i++) begin
      serial_in = bits[i];
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    checks++; if (po_l !== 4'h0) begin errors++; $display("FAIL reset_po_l got %h want 0", po_l); end
    checks++; if (po_m !== 4'h0) begin errors++; $display("FAIL reset_po_m got %h want 0", po_m); end
    checks++; if (ov_l !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ov_l); end
    checks++; if (ovr_l !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", ovr_l); end
    checks++; if (pe_l !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", pe_l); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lsb_msb;
    logic [4:0] bits;
    bits = {1'b1, 4'b1101};
    for (int i = 0; i < FL; i++) begin
      serial_in = bits[i];
      in_valid  = 1'b1;
      tick();
      if (i < FL - 1) begin
        checks++;
        if (ov_l !== 1'b0) begin
          errors++; $display("FAIL early_valid bit %0d got %b want 0", i, ov_l);
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (ov_l !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b want 1", ov_l); end
    checks++; if (po_l !== 4'b1101) begin errors++; $display("FAIL lsb_word got %b want 1101", po_l); end
    checks++; if (ov_m !== 1'b1) begin errors++; $display("FAIL msb_valid got %b want 1", ov_m); end
    checks++; if (po_m !== 4'b1011) begin errors++; $display("FAIL msb_word got %b want 1011", po_m); end
    consume();
    checks++; if (ov_l !== 1'b0) begin errors++; $display("FAIL consume_valid got %b want 0", ov_l); end
    checks++; if (po_l !== 4'b1101) begin errors++; $display("FAIL consume_hold got %b want 1101", po_l); end
  endtask

  task automatic test_gaps_sync;
    send_seq(4'b1101, 2, 1'b0);
    checks++; if (po_l !== 4'b1101) begin errors++; $display("FAIL gap_word got %b want 1101", po_l); end
    checks++; if (ov_l !== 1'b1) begin errors++; $display("FAIL gap_valid got %b want 1", ov_l); end
    consume();
    serial_in = 1'b1; in_valid = 1'b1; tick();
    serial_in = 1'b0; tick();
    // in_valid stays high during the sync cycle and must be ignored
    frame_sync = 1'b1; tick();
    frame_sync = 1'b0; in_valid = 1'b0;
    checks++; if (ov_l !== 1'b0) begin errors++; $display("FAIL sync_valid got %b want 0", ov_l); end
    checks++; if (po_l !== 4'b1101) begin errors++; $display("FAIL sync_hold got %b want 1101", po_l); end
    send_seq(4'b1111, 0, 1'b0);
    checks++; if (po_l !== 4'b1111) begin errors++; $display("FAIL sync_word_l got %b want 1111", po_l); end
    checks++; if (po_m !== 4'b1111) begin errors++; $display("FAIL sync_word_m got %b want 1111", po_m); end
    checks++; if (ov_l !== 1'b1) begin errors++; $display("FAIL sync_word_v got %b want 1", ov_l); end
    consume();
  endtask

  task automatic test_overrun;
    out_ready = 1'b0;
    send_seq(4'b0011, 0, 1'b0);
    send_seq(4'b0101, 0, 1'b0);
    checks++; if (po_l !== 4'h3) begin errors++; $display("FAIL ovr_word_l got %h want 3", po_l); end
    checks++; if (po_m !== 4'hC) begin errors++; $display("FAIL ovr_word_m got %h want c", po_m); end
    checks++; if (ov_l !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", ov_l); end
    checks++; if (ovr_l !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", ovr_l); end
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    checks++; if (ovr_l !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b want 0", ovr_l); end
    checks++; if (po_l !== 4'h3) begin errors++; $display("FAIL ovr_hold got %h want 3", po_l); end
    consume();
  endtask

  task automatic test_back_to_back;
    logic [4:0] bits;
    send_seq(4'b1010, 0, 1'b0);
    checks++; if (po_l !== 4'hA) begin errors++; $display("FAIL b2b_first got %h want a", po_l); end
    bits = {^4'b0110, 4'b0110};
    for (int i = 0; i < FL; i++) begin
      serial_in = bits[i];
      in_valid  = 1'b1;
      out_ready = (i == FL - 1);
      tick();
      checks++;
      if (ov_l !== 1'b1) begin errors++; $display("FAIL b2b_gap bit %0d got %b want 1", i, ov_l); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (po_l !== 4'h6) begin errors++; $display("FAIL b2b_second_l got %h want 6", po_l); end
    checks++; if (po_m !== 4'h6) begin errors++; $display("FAIL b2b_second_m got %h want 6", po_m); end
    checks++; if (ovr_l !== 1'b0) begin errors++; $display("FAIL b2b_ovr got %b want 0", ovr_l); end
    consume();
  endtask

  task automatic test_reset_mid;
    send_seq(4'b1001, 0, 1'b0);
    serial_in = 1'b1; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (po_l !== 4'h0) begin errors++; $display("FAIL async_po got %h want 0", po_l); end
    checks++; if (ov_l !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", ov_l); end
    checks++; if (po_m !== 4'h0) begin errors++; $display("FAIL async_po_m got %h want 0", po_m); end
    #1 rst = 1'b0;
    tick();
    send_seq(4'b0001, 0, 1'b0);
    checks++; if (po_l !== 4'b0001) begin errors++; $display("FAIL post_rst_l got %b want 0001", po_l); end
    checks++; if (po_m !== 4'b1000) begin errors++; $display("FAIL post_rst_m got %b want 1000", po_m); end
    consume();
  endtask

  task automatic test_parity;
`ifdef SIPO_DESER_PARITY_EN
    send_seq(4'b0111, 0, 1'b1);
    checks++; if (pe_l !== 1'b1) begin errors++; $display("FAIL par_err got %b want 1", pe_l); end
    checks++; if (po_l !== 4'b0111) begin errors++; $display("FAIL par_word got %b want 0111", po_l); end
    checks++; if (ov_l !== 1'b1) begin errors++; $display("FAIL par_valid got %b want 1", ov_l); end
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    checks++; if (pe_l !== 1'b0) begin errors++; $display("FAIL par_clr got %b want 0", pe_l); end
`else
    send_seq(4'b0111, 0, 1'b1);
    checks++; if (pe_l !== 1'b0) begin errors++; $display("FAIL par_tied got %b want 0", pe_l); end
    checks++; if (po_l !== 4'b0111) begin errors++; $display("FAIL par_word got %b want 0111", po_l); end
`endif
    consume();
  endtask

  initial begin
    rst = 1'b1; serial_in = 1'b0; in_valid = 1'b0; frame_sync = 1'b0;
    out_ready = 1'b0; overrun_clr = 1'b0;
    test_reset();
    test_lsb_msb();
    test_gaps_sync();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 0; 0 means the first serial bit lands in bit 0, 1 means it lands in bit WIDTH-1.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port serial_in, input, 1, serial data bit, sampled only when in_valid=1.
REQ-006 SHALL have port in_valid, input, 1, qualifies serial_in for the current cycle.
REQ-007 SHALL have port frame_sync, input, 1, discards any partial word and restarts bit counting.
REQ-008 SHALL have port parallel_out, output, WIDTH, assembled word held in the output register.
REQ-009 SHALL have port out_valid, output, 1, parallel_out holds an unconsumed word.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the word when out_valid and out_ready are both 1.
REQ-011 SHALL have port overrun, output, 1, sticky flag set when a completed word is dropped.
REQ-012 SHALL have port overrun_clr, input, 1, clears overrun synchronously.
REQ-013 SHALL have port parity_err, output, 1, sticky flag set on a parity mismatch (see Configuration).

Function
REQ-014 SHALL use a two-state FSM: IDLE (bit count 0) and SHIFT (partial word, count 1..N-1), where N is the frame length in bits.
REQ-015 SHALL, in IDLE with in_valid=1, sample the bit, set the count to 1, and go to SHIFT.
REQ-016 SHALL, in SHIFT with in_valid=1, sample the bit and increment the count.
REQ-017 SHALL, on sampling bit N, return to IDLE with count 0 in the same edge.
REQ-018 SHALL hold the shift register and count unchanged in any cycle with in_valid=0.
REQ-019 SHALL size the bit counter at $clog2(N+1) bits; the counter never exceeds N-1 when registered.
REQ-020 SHALL, on the edge sampling bit N, load the word into parallel_out and set out_valid=1, visible in the following cycle (1-cycle latency from the last bit).
REQ-021 SHALL clear out_valid on the edge where out_valid=1 and out_ready=1, unless a new word completes on the same edge.
REQ-022 SHALL, when a word completes on the same edge as a handshake, load the new word and keep out_valid=1 without a gap.
REQ-023 SHALL, when a word completes while out_valid=1 and out_ready=0, drop the new word, keep parallel_out unchanged, and set overrun.
REQ-024 SHALL have frame_sync=1 force IDLE with count 0, discarding the partial word, and ignore in_valid in that cycle.
REQ-025 SHALL NOT have frame_sync affect parallel_out or out_valid.
REQ-026 SHALL clear overrun on overrun_clr=1; when set and clear coincide, set wins.
REQ-027 SHALL hold parallel_out stable whenever out_valid=1 and no handshake occurs.

Reset
REQ-028 SHALL, on rst=1, immediately force the FSM to IDLE and the count to 0.
REQ-029 SHALL, on rst=1, clear the shift register, parallel_out, out_valid, overrun and parity_err to 0, independent of clk.
REQ-030 SHALL, on reset asserted mid-word, lose the partial word; the first valid bit after deassertion is bit 1 of a new word.

Configuration
REQ-031 SHALL, with macro SIPO_DESER_PARITY_EN defined, use N=WIDTH+1; the last serial bit is an even-parity bit covering the WIDTH data bits.
REQ-032 SHALL, with SIPO_DESER_PARITY_EN defined, set parity_err (sticky, cleared by overrun_clr) on a mismatch and still deliver the word.
REQ-033 SHALL, without SIPO_DESER_PARITY_EN, use N=WIDTH and tie parity_err to 0.

Structure
REQ-034 SHALL place the FSM state enum (IDLE, SHIFT) and the WIDTH legal-range constants in shared package sipo_pkg.
REQ-035 SHALL implement the shift register and bit counter in sub-module sipo_shift_core; output register, handshake and flags stay in sipo_deser.

Verification
REQ-036 SHALL cover LSB-first: WIDTH=4, MSB_FIRST=0, bits 1,0,1,1 with in_valid=1 -> parallel_out=4'b1101, out_valid=1 one cycle after the 4th bit.
REQ-037 SHALL cover MSB-first: WIDTH=4, MSB_FIRST=1, same bits -> parallel_out=4'b1011.
REQ-038 SHALL cover gaps and sync: in_valid gaps between bits -> same word; frame_sync after 2 bits, then 1,1,1,1 -> parallel_out=4'b1111.
REQ-039 SHALL cover overrun: out_ready=0, two words 4'h3 then 4'h5 -> parallel_out=4'h3, overrun=1; overrun_clr -> overrun=0.
REQ-040 SHALL cover back-to-back: out_ready=1 with continuous bits -> out_valid never drops between words 4'hA and 4'h6.
REQ-041 SHALL cover reset and parity: rst after 3 bits -> all outputs 0; with parity enabled, data 4'b0111 and parity 0 -> parity_err=1.
